// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - E-register inputs, forwarding taps and M-register outputs of the Y86-64 execute stage
interface execute_stage_if #(
  parameter int DATA_W = 64
);
  logic [3:0]        E_stat;
  logic [3:0]        E_icode;
  logic [3:0]        E_ifun;
  logic [DATA_W-1:0] E_valC;
  logic [DATA_W-1:0] E_valA;
  logic [DATA_W-1:0] E_valB;
  logic [3:0]        E_dstE;
  logic [3:0]        E_dstM;
  logic [3:0]        m_stat;
  logic [3:0]        W_stat;
  logic              M_bubble;
  logic              e_Cnd;
  logic [3:0]        e_dstE;
  logic [DATA_W-1:0] e_valE;
  logic [3:0]        M_stat;
  logic [3:0]        M_icode;
  logic              M_Cnd;
  logic [DATA_W-1:0] M_valE;
  logic [DATA_W-1:0] M_valA;
  logic [3:0]        M_dstE;
  logic [3:0]        M_dstM;
  logic [2:0]        cc_out;

  modport master (
    output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
    output m_stat, W_stat, M_bubble,
    input  e_Cnd, e_dstE, e_valE,
    input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, cc_out
  );

  modport slave (
    input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
    input  m_stat, W_stat, M_bubble,
    output e_Cnd, e_dstE, e_valE,
    output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, cc_out
  );
endinterface

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - Y86-64 execute stage: ALU, condition codes, cmov/jXX condition, M pipeline register
// Defining EXEC_PERF_CNT_EN adds the perf_ops/perf_bubbles/perf_taken saturating counters.
module execute_stage #(
  parameter int         DATA_W = 64,
  parameter logic [3:0] RNONE  = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  execute_stage_if.slave     eif
`ifdef EXEC_PERF_CNT_EN
  ,
  output logic [31:0]        perf_ops,
  output logic [31:0]        perf_bubbles,
  output logic [31:0]        perf_taken
`endif
);
  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;
  localparam logic [3:0] S_AOK   = 4'h1;
  localparam int         MSB     = DATA_W - 1;
  localparam logic [DATA_W-1:0] STACK_STEP = DATA_W'(8);

  logic [DATA_W-1:0] alu_a, alu_b, alu_r;
  logic [3:0]        alu_fn;
  logic              alu_of, lt, cond, e_cnd, set_cc;
  logic [3:0]        e_dste;
  logic [2:0]        cc_d, cc_q;
  logic [3:0]        mr_stat_d, mr_stat_q, mr_icode_d, mr_icode_q;
  logic [3:0]        mr_dste_d, mr_dste_q, mr_dstm_d, mr_dstm_q;
  logic              mr_cnd_d, mr_cnd_q;
  logic [DATA_W-1:0] mr_vale_d, mr_vale_q, mr_vala_d, mr_vala_q;
`ifdef EXEC_PERF_CNT_EN
  logic [31:0]       ops_d, ops_q, bub_d, bub_q, taken_d, taken_q;
`endif

  function automatic logic stat_is_exc(input logic [3:0] s);
    return (s == 4'h2) || (s == 4'h3) || (s == 4'h4);
  endfunction

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    alu_r = '0;
    alu_of = 1'b0;
    lt = 1'b0;
    cond = 1'b0;
    case (eif.E_icode)
      I_CMOV, I_OPQ:           alu_a = eif.E_valA;
      I_IRMOV, I_RMMOV, I_MRMOV: alu_a = eif.E_valC;
      I_CALL, I_PUSH:          alu_a = -STACK_STEP;
      I_RET, I_POP:            alu_a = STACK_STEP;
      default:                 alu_a = '0;
    endcase
    case (eif.E_icode)
      I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: alu_b = eif.E_valB;
      default:                                               alu_b = '0;
    endcase

    alu_fn = (eif.E_icode == I_OPQ) ? eif.E_ifun : 4'h0;
    case (alu_fn)
      4'h0: begin
        alu_r  = alu_b + alu_a;
        alu_of = (alu_a[MSB] == alu_b[MSB]) && (alu_r[MSB] != alu_a[MSB]);
      end
      4'h1: begin
        alu_r  = alu_b - alu_a;
        alu_of = (alu_a[MSB] != alu_b[MSB]) && (alu_r[MSB] != alu_b[MSB]);
      end
      4'h2:    alu_r = alu_a & alu_b;
      4'h3:    alu_r = alu_a ^ alu_b;
      default: alu_r = '0;
    endcase

    // Condition is taken from the CC already latched, never from this cycle's flags.
    lt = cc_q[1] ^ cc_q[0];
    case (eif.E_ifun)
      4'h0:    cond = 1'b1;
      4'h1:    cond = lt | cc_q[2];
      4'h2:    cond = lt;
      4'h3:    cond = cc_q[2];
      4'h4:    cond = ~cc_q[2];
      4'h5:    cond = ~lt;
      4'h6:    cond = ~lt & ~cc_q[2];
      default: cond = 1'b0;
    endcase
    e_cnd  = cond && ((eif.E_icode == I_CMOV) || (eif.E_icode == I_JXX));
    e_dste = ((eif.E_icode == I_CMOV) && !e_cnd) ? RNONE : eif.E_dstE;

    set_cc = (eif.E_icode == I_OPQ) && !stat_is_exc(eif.m_stat) && !stat_is_exc(eif.W_stat);
    cc_d   = set_cc ? {alu_r == '0, alu_r[MSB], alu_of} : cc_q;

    if (eif.M_bubble) begin
      mr_stat_d  = S_AOK;
      mr_icode_d = I_NOP;
      mr_cnd_d   = 1'b0;
      mr_vale_d  = '0;
      mr_vala_d  = '0;
      mr_dste_d  = RNONE;
      mr_dstm_d  = RNONE;
    end else begin
      mr_stat_d  = eif.E_stat;
      mr_icode_d = eif.E_icode;
      mr_cnd_d   = e_cnd;
      mr_vale_d  = alu_r;
      mr_vala_d  = eif.E_valA;
      mr_dste_d  = e_dste;
      mr_dstm_d  = eif.E_dstM;
    end

`ifdef EXEC_PERF_CNT_EN
    ops_d   = ops_q;
    bub_d   = bub_q;
    taken_d = taken_q;
    if (eif.M_bubble) begin
      if (bub_q != 32'hFFFF_FFFF) bub_d = bub_q + 32'd1;
    end else begin
      if ((eif.E_icode != 4'h0) && (eif.E_icode != I_NOP) && (eif.E_stat == S_AOK) &&
          (ops_q != 32'hFFFF_FFFF))
        ops_d = ops_q + 32'd1;
      if ((eif.E_icode == I_JXX) && e_cnd && (taken_q != 32'hFFFF_FFFF))
        taken_d = taken_q + 32'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_q       <= 3'b100;
      mr_stat_q  <= S_AOK;
      mr_icode_q <= I_NOP;
      mr_cnd_q   <= 1'b0;
      mr_vale_q  <= '0;
      mr_vala_q  <= '0;
      mr_dste_q  <= RNONE;
      mr_dstm_q  <= RNONE;
`ifdef EXEC_PERF_CNT_EN
      ops_q      <= '0;
      bub_q      <= '0;
      taken_q    <= '0;
`endif
    end else begin
      cc_q       <= cc_d;
      mr_stat_q  <= mr_stat_d;
      mr_icode_q <= mr_icode_d;
      mr_cnd_q   <= mr_cnd_d;
      mr_vale_q  <= mr_vale_d;
      mr_vala_q  <= mr_vala_d;
      mr_dste_q  <= mr_dste_d;
      mr_dstm_q  <= mr_dstm_d;
`ifdef EXEC_PERF_CNT_EN
      ops_q      <= ops_d;
      bub_q      <= bub_d;
      taken_q    <= taken_d;
`endif
    end
  end

  assign eif.e_Cnd   = e_cnd;
  assign eif.e_dstE  = e_dste;
  assign eif.e_valE  = alu_r;
  assign eif.M_stat  = mr_stat_q;
  assign eif.M_icode = mr_icode_q;
  assign eif.M_Cnd   = mr_cnd_q;
  assign eif.M_valE  = mr_vale_q;
  assign eif.M_valA  = mr_vala_q;
  assign eif.M_dstE  = mr_dste_q;
  assign eif.M_dstM  = mr_dstm_q;
  assign eif.cc_out  = cc_q;
`ifdef EXEC_PERF_CNT_EN
  assign perf_ops     = ops_q;
  assign perf_bubbles = bub_q;
  assign perf_taken   = taken_q;
`endif
endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed plus random checks of execute_stage against an arithmetic reference model
module tb_execute_stage;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  execute_stage_if #(.DATA_W(64)) eif();
`ifdef EXEC_PERF_CNT_EN
  logic [31:0] perf_ops, perf_bubbles, perf_taken;
  longint exp_ops = 0, exp_bub = 0, exp_taken = 0;
`endif

  execute_stage #(.DATA_W(64), .RNONE(4'hF)) dut (
    .clk(clk),
    .rst(rst),
    .eif(eif)
`ifdef EXEC_PERF_CNT_EN
    ,
    .perf_ops(perf_ops),
    .perf_bubbles(perf_bubbles),
    .perf_taken(perf_taken)
`endif
  );

  int n_assert = 0;
  int n_fail = 0;

  // reference state: CC bits and the expected M register
  logic       r_zf = 1'b1, r_sf = 1'b0, r_of = 1'b0;
  logic [3:0] x_stat = 4'h1, x_icode = 4'h1, x_dste = 4'hF, x_dstm = 4'hF;
  logic       x_cnd = 1'b0;
  logic [63:0] x_vale = '0, x_vala = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ref_alu(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         output logic [63:0] val, output logic zf, output logic sf, output logic of);
    logic [63:0] x, y;
    logic signed [64:0] wide;
    if (icode == 2 || icode == 6) x = a;
    else if (icode >= 3 && icode <= 5) x = c;
    else if (icode == 8 || icode == 4'hA) x = 64'hFFFF_FFFF_FFFF_FFF8;
    else if (icode == 9 || icode == 4'hB) x = 64'd8;
    else x = 64'd0;
    y = (icode >= 4 && icode <= 4'hB && icode != 7) ? b : 64'd0;
    of = 1'b0;
    if (icode == 6 && ifun == 1) begin
      wide = $signed({y[63], y}) - $signed({x[63], x});
      val = wide[63:0];
      of = wide[64] ^ wide[63];
    end else if (icode == 6 && ifun == 2) val = x & y;
    else if (icode == 6 && ifun == 3) val = x ^ y;
    else if (icode == 6 && ifun > 3) val = 64'd0;
    else begin
      wide = $signed({y[63], y}) + $signed({x[63], x});
      val = wide[63:0];
      of = wide[64] ^ wide[63];
    end
    zf = (val == 64'd0);
    sf = val[63];
  endtask

  function automatic logic ref_cond(input logic [3:0] ifun, input logic zf, input logic sf, input logic of);
    logic less;
    less = sf ^ of;
    case (ifun)
      4'd0: return 1'b1;
      4'd1: return less | zf;
      4'd2: return less;
      4'd3: return zf;
      4'd4: return !zf;
      4'd5: return !less;
      4'd6: return !less && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_exc(input logic [3:0] s);
    return s >= 4'd2 && s <= 4'd4;
  endfunction

  task automatic do_cycle();
    logic [63:0] v;
    logic zf, sf, of, cnd;
    logic [3:0] dste;
    #1;
    ref_alu(eif.E_icode, eif.E_ifun, eif.E_valA, eif.E_valB, eif.E_valC, v, zf, sf, of);
    cnd = (eif.E_icode == 2 || eif.E_icode == 7) ? ref_cond(eif.E_ifun, r_zf, r_sf, r_of) : 1'b0;
    dste = (eif.E_icode == 2 && !cnd) ? 4'hF : eif.E_dstE;
    check("e_valE", eif.e_valE, v);
    check("e_Cnd", 64'(eif.e_Cnd), 64'(cnd));
    check("e_dstE", 64'(eif.e_dstE), 64'(dste));
    @(posedge clk);
    if (rst) begin
      {r_zf, r_sf, r_of} = 3'b100;
      x_stat = 1; x_icode = 1; x_cnd = 0; x_vale = 0; x_vala = 0; x_dste = 4'hF; x_dstm = 4'hF;
`ifdef EXEC_PERF_CNT_EN
      exp_ops = 0; exp_bub = 0; exp_taken = 0;
`endif
    end else begin
      if (eif.E_icode == 6 && !is_exc(eif.m_stat) && !is_exc(eif.W_stat)) {r_zf, r_sf, r_of} = {zf, sf, of};
      if (eif.M_bubble) begin
        x_stat = 1; x_icode = 1; x_cnd = 0; x_vale = 0; x_vala = 0; x_dste = 4'hF; x_dstm = 4'hF;
`ifdef EXEC_PERF_CNT_EN
        if (exp_bub < 64'hFFFF_FFFF) exp_bub++;
`endif
      end else begin
        x_stat = eif.E_stat; x_icode = eif.E_icode; x_cnd = cnd; x_vale = v;
        x_vala = eif.E_valA; x_dste = dste; x_dstm = eif.E_dstM;
`ifdef EXEC_PERF_CNT_EN
        if (eif.E_icode > 1 && eif.E_stat == 1 && exp_ops < 64'hFFFF_FFFF) exp_ops++;
        if (eif.E_icode == 7 && cnd && exp_taken < 64'hFFFF_FFFF) exp_taken++;
`endif
      end
    end
    @(negedge clk);
    check("M_stat", 64'(eif.M_stat), 64'(x_stat));
    check("M_icode", 64'(eif.M_icode), 64'(x_icode));
    check("M_Cnd", 64'(eif.M_Cnd), 64'(x_cnd));
    check("M_valE", eif.M_valE, x_vale);
    check("M_valA", eif.M_valA, x_vala);
    check("M_dstE", 64'(eif.M_dstE), 64'(x_dste));
    check("M_dstM", 64'(eif.M_dstM), 64'(x_dstm));
    check("cc_out", 64'(eif.cc_out), 64'({r_zf, r_sf, r_of}));
`ifdef EXEC_PERF_CNT_EN
    check("perf_ops", 64'(perf_ops), 64'(exp_ops));
    check("perf_bubbles", 64'(perf_bubbles), 64'(exp_bub));
    check("perf_taken", 64'(perf_taken), 64'(exp_taken));
`endif
  endtask

  task automatic set_e(input logic [3:0] icode, input logic [3:0] ifun, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input logic [3:0] dste);
    eif.E_stat = 4'h1; eif.E_icode = icode; eif.E_ifun = ifun;
    eif.E_valA = a; eif.E_valB = b; eif.E_valC = c; eif.E_dstE = dste; eif.E_dstM = 4'hF;
  endtask

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'hFFFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    set_e(4'h0, 4'h0, 0, 0, 0, 4'hF);
    eif.m_stat = 4'h1; eif.W_stat = 4'h1; eif.M_bubble = 1'b0;
    @(negedge clk);
    do_cycle();
    do_cycle();
    check("reset_icode", 64'(eif.M_icode), 64'h1);
    check("reset_cc", 64'(eif.cc_out), 64'b100);
    rst = 1'b0;

    set_e(4'h6, 4'h0, 64'd5, 64'd7, 0, 4'h3);
    do_cycle();
    check("add_M_valE", eif.M_valE, 64'd12);
    check("add_cc", 64'(eif.cc_out), 64'b000);

    set_e(4'h6, 4'h1, 64'd9, 64'd9, 0, 4'h4);
    do_cycle();
    check("sub_zf_cc", 64'(eif.cc_out), 64'b100);
    set_e(4'h2, 4'h3, 64'd77, 0, 0, 4'h2);
    do_cycle();
    check("cmove_dstE", 64'(eif.M_dstE), 64'h2);
    set_e(4'h2, 4'h4, 64'd77, 0, 0, 4'h2);
    do_cycle();
    check("cmovne_dstE", 64'(eif.M_dstE), 64'hF);

    set_e(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 0, 4'h1);
    do_cycle();
    check("ovf_valE", eif.M_valE, 64'hFFFF_FFFF_FFFF_FFFE);
    check("ovf_cc", 64'(eif.cc_out), 64'b011);
    eif.W_stat = 4'h3;
    set_e(4'h6, 4'h0, 64'd0, 64'd0, 0, 4'h1);
    do_cycle();
    check("wstat_cc_hold", 64'(eif.cc_out), 64'b011);
    eif.W_stat = 4'h1;

    set_e(4'hA, 4'h0, 0, 64'h100, 0, 4'h4);
    do_cycle();
    check("push_valE", eif.M_valE, 64'hF8);
    set_e(4'h8, 4'h0, 0, 64'h200, 0, 4'h4);
    do_cycle();
    check("call_valE", eif.M_valE, 64'h1F8);
    set_e(4'hB, 4'h0, 0, 64'hF8, 0, 4'h4);
    do_cycle();
    check("pop_valE", eif.M_valE, 64'h100);

    eif.M_bubble = 1'b1;
    set_e(4'h6, 4'h1, 64'd1, 64'd1, 0, 4'h5);
    do_cycle();
    check("bubble_icode", 64'(eif.M_icode), 64'h1);
    check("bubble_cc", 64'(eif.cc_out), 64'b100);
    set_e(4'h6, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 4'h5);
    rst = 1'b1;
    do_cycle();
    check("bubble_rst_cc", 64'(eif.cc_out), 64'b100);
    rst = 1'b0;
    eif.M_bubble = 1'b0;

    for (int i = 0; i < 400; i++) begin
      set_e(4'($urandom_range(0, 11)), 4'($urandom_range(0, 7)), rnd_val(), rnd_val(), rnd_val(),
            4'($urandom_range(0, 15)));
      eif.E_stat = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
      eif.E_dstM = 4'($urandom_range(0, 15));
      eif.m_stat = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
      eif.W_stat = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(2, 4)) : 4'h1;
      eif.M_bubble = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 39) == 0);
      do_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
